rom_sample_reader: RTL
======================

# rom_sample_reader

Read-side sequencer for the synchronous-read waveform ROM in the signal generator. It drives the ROM address from a phase accumulator stepped by a programmable increment, absorbs the ROM's one-cycle read latency, and delivers samples downstream on a valid/ready stream. It sits between the frequency control inputs and the DAC/plotting sink, with the ROM instance alongside it.

## Interface
- ADDRESS_WIDTH, 8, ROM address width; phase accumulator width
- DATA_WIDTH, 8, ROM word and sample width
- INCR_WIDTH, 8, phase increment width; must be ≤ ADDRESS_WIDTH
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  permits new ROM reads
- incr  in  INCR_WIDTH  phase step per issued read, zero-extended
- addr  out  ADDRESS_WIDTH  ROM address (to ROM addr)
- rom_dout  in  DATA_WIDTH  ROM data (from ROM dout), valid one cycle after addr is sampled
- sample  out  DATA_WIDTH  output sample
- sample_valid  out  1  sample holds valid data
- sample_ready  in  1  downstream accepts sample

## Operation
- Phase register `phase` (ADDRESS_WIDTH bits); addr = phase (with offset, see Configuration).
- Issue in cycle k when en=1 and credit available: ROM samples addr at end of cycle k; phase <= phase + incr at the same edge, modulo 2^ADDRESS_WIDTH (wrap, no saturation).
- inflight flag set for the cycle after an issue; rom_dout captured into the 2-entry output buffer at the end of that cycle.
- Credit rule: issue only if (buffer occupancy + inflight − pop this cycle) < 2; no sample is ever dropped or overwritten.
- Pop: sample_valid & sample_ready at an edge; buffer is FIFO-ordered, head drives sample.
- sample and sample_valid are registered; sample stable while sample_valid=1 and sample_ready=0.
- en deasserted: no new issues; in-flight read still lands and is delivered; phase holds.
- incr change takes effect on the next issue; incr=0 repeats the same address indefinitely.
- Buffer states: EMPTY, ONE, FULL; push and pop in the same cycle leave occupancy unchanged.

## Timing
- Reset values: phase=0, addr=0 (offset term excluded), inflight=0, buffer EMPTY, sample_valid=0, sample=0.
- Latency: issue in cycle k → sample_valid in cycle k+2 when buffer was empty.
- Steady state with sample_ready=1: one sample per cycle, throughput 1.
- Reset mid-operation: in-flight read and buffer contents discarded; first post-reset issue reads address 0.
- Simultaneous push and pop at FULL: cannot occur (credit rule); at ONE: head replaced by the incoming sample, valid stays 1.

## Configuration
- ROM_SAMPLE_READER_OFFSET_EN defined: adds input `offset` (ADDRESS_WIDTH); addr = phase + offset mod 2^ADDRESS_WIDTH, combinational, sampled with the issue. Used for the second-channel phase-shifted output.
- Undefined: no offset port; addr = phase.

## Structure
- Shared package sig_pkg: default ADDRESS_WIDTH/DATA_WIDTH/INCR_WIDTH constants and the buffer state enum (EMPTY, ONE, FULL).
- One sub-module: sample_skid_buf (2-entry valid/ready buffer with push, pop and occupancy output); phase accumulator and credit logic live in the top.

## Test plan
- Reset, en=1, incr=1, sample_ready=1, ROM loaded addr→addr: sample_valid rises 2 cycles after the first issue, samples 0,1,2,… one per cycle.
- incr=64, ADDRESS_WIDTH=8: address sequence 0,64,128,192,0 (wrap); samples match ROM at those addresses.
- sample_ready=0 for 10 cycles mid-stream: at most 2 samples buffered, issues stop, addr holds; on release the stream resumes with no gaps, duplicates or losses.
- en pulsed high for 1 cycle: exactly one sample delivered; phase advances by incr exactly once.
- rst asserted with inflight=1 and buffer FULL: next cycle sample_valid=0, addr=0; no stale sample appears afterwards.
- With ROM_SAMPLE_READER_OFFSET_EN, offset=200, incr=100: addr sequence 200,44,144 (mod 256).

Source files
------------

// File: rtl/sig_pkg.sv
// rtl/sig_pkg.sv - shared widths and output-buffer state encoding for the waveform reader
package sig_pkg;

    localparam int DEF_ADDRESS_WIDTH = 8;
    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_INCR_WIDTH    = 8;

    // Encoded so that the state value doubles as the buffer occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/rom_sample_reader_if.sv
// rtl/rom_sample_reader_if.sv - ROM address/data bus plus downstream sample stream
interface rom_sample_reader_if #(
    parameter int ADDRESS_WIDTH = sig_pkg::DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = sig_pkg::DEF_DATA_WIDTH
);
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    rom_dout;
    logic [DATA_WIDTH-1:0]    sample;
    logic                     sample_valid;
    logic                     sample_ready;

    modport master (
        output addr,
        input  rom_dout,
        output sample,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  addr,
        output rom_dout,
        input  sample,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/sample_skid_buf.sv
// rtl/sample_skid_buf.sv - two-entry FIFO-ordered sample buffer with registered head
module sample_skid_buf
    import sig_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  valid,
    output logic [1:0]            occupancy
);

    buf_state_t            state;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;

    // Occupancy state machine; the head register is the sample seen downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_q <= push_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_q <= push_data;
                    end else if (push) begin
                        tail_q <= push_data;
                        state  <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // The reader's credit check keeps push away from a full buffer
                    // unless a pop frees a slot in the same cycle.
                    if (pop) begin
                        head_q <= tail_q;
                        if (push) begin
                            tail_q <= push_data;
                        end else begin
                            state <= ONE;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign head      = head_q;
    assign valid     = (state != EMPTY);
    assign occupancy = state;

endmodule

// File: rtl/rom_sample_reader.sv
// rtl/rom_sample_reader.sv - phase-accumulator ROM reader with credit-based sample stream; ROM_SAMPLE_READER_OFFSET_EN adds a phase offset input
module rom_sample_reader
    import sig_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int INCR_WIDTH    = DEF_INCR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [INCR_WIDTH-1:0]    incr,
`ifdef ROM_SAMPLE_READER_OFFSET_EN
    input  logic [ADDRESS_WIDTH-1:0] offset,
`endif
    rom_sample_reader_if.master      bus
);

    logic [ADDRESS_WIDTH-1:0] phase;
    logic                     inflight;
    logic [1:0]               occupancy;
    logic                     pop;
    logic                     issue;

    assign pop = bus.sample_valid & bus.sample_ready;

    // A read may start only if the buffer will still have room for it when the
    // data lands: occupancy + inflight - pop < 2, rearranged to avoid underflow.
    assign issue = en && (({1'b0, occupancy} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

`ifdef ROM_SAMPLE_READER_OFFSET_EN
    assign bus.addr = phase + offset;
`else
    assign bus.addr = phase;
`endif

    // Phase advances once per issued read; the ROM returns data one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                phase <= phase + ADDRESS_WIDTH'(incr);
            end
        end
    end

    sample_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (bus.rom_dout),
        .pop       (pop),
        .head      (bus.sample),
        .valid     (bus.sample_valid),
        .occupancy (occupancy)
    );

endmodule
